// File: rtl/gate_sweep.sv
// rtl/gate_sweep.sv - exhaustive truth-table sweep of a selectable N-input gate
// Each input vector is held for HOLD cycles; the gate result is captured into table_out.
module gate_sweep #(
  parameter int N    = 2,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  output logic [N-1:0]      vec,
  output logic              y,
  output logic [2**N-1:0]   table_out,
  output logic              busy,
  output logic              done
);

  localparam int TW = 2**N;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [TW-1:0]   table_q, table_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic            gate_val;
  logic            hold_end;
  logic            last_vec;

  // Gate is evaluated purely from registered op/vec so y never glitches with inputs
  always_comb begin
    gate_val = 1'b0;
    case (op_q)
      3'b000:  gate_val = &vec_q;
      3'b001:  gate_val = |vec_q;
      3'b010:  gate_val = ^vec_q;
      3'b011:  gate_val = ~(&vec_q);
      3'b100:  gate_val = ~(|vec_q);
      3'b101:  gate_val = ~(^vec_q);
      3'b110:  gate_val = vec_q[0];
      3'b111:  gate_val = ~vec_q[0];
      default: gate_val = 1'b0;
    endcase
  end

  assign hold_end = (hold_q == HW'(HOLD - 1));
  assign last_vec = (vec_q == {N{1'b1}});

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vec_d   = vec_q;
    table_d = table_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          op_d    = op;
          vec_d   = '0;
          table_d = '0;
          hold_d  = '0;
        end
      end
      APPLY: begin
        if (hold_end) begin
          table_d[vec_q] = gate_val;
          hold_d         = '0;
          // vec stops at the last vector instead of wrapping back to 0
          if (last_vec) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + N'(1);
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      vec_q   <= '0;
      table_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      hold_q  <= hold_d;
    end
  end

  assign vec       = vec_q;
  assign table_out = table_q;
  assign busy      = (state_q == APPLY);
  assign done      = (state_q == DONE);
  assign y         = busy & gate_val;

endmodule

// File: tb/tb_gate_sweep.sv
// tb/tb_gate_sweep.sv - directed checks of gate_sweep in three parameter sets
// Inputs change and outputs are sampled on the falling clock edge.
module tb_gate_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [2:0] op_a = 3'd0, op_b = 3'd0, op_c = 3'd0;
  logic [1:0] vec_a, vec_c;
  logic [2:0] vec_b;
  logic [3:0] tab_a, tab_c;
  logic [7:0] tab_b;
  logic       y_a, y_b, y_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

  int n_checks = 0;
  int n_fail   = 0;

  gate_sweep #(.N(2), .HOLD(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .op(op_a), .vec(vec_a), .y(y_a),
    .table_out(tab_a), .busy(busy_a), .done(done_a));
  gate_sweep #(.N(3), .HOLD(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .op(op_b), .vec(vec_b), .y(y_b),
    .table_out(tab_b), .busy(busy_b), .done(done_b));
  gate_sweep #(.N(2), .HOLD(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .op(op_c), .vec(vec_c), .y(y_c),
    .table_out(tab_c), .busy(busy_c), .done(done_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_tab(input int sel);
    case (sel)
      0: return 32'(tab_a);
      1: return 32'(tab_b);
      default: return 32'(tab_c);
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [31:0] get_vec(input int sel);
    case (sel)
      0: return 32'(vec_a);
      1: return 32'(vec_b);
      default: return 32'(vec_c);
    endcase
  endfunction

  task automatic drive(input int sel, input logic s, input logic [2:0] o);
    case (sel)
      0: begin start_a = s; op_a = o; end
      1: begin start_b = s; op_b = o; end
      default: begin start_c = s; op_c = o; end
    endcase
  endtask

  // Pulse start, scramble op after acceptance, wait for done and check the table
  task automatic sweep(input int sel, input logic [2:0] o, input int exp_cyc,
                       input logic [31:0] exp_tab, input string tag);
    int cyc;
    @(negedge clk);
    drive(sel, 1'b1, o);
    @(negedge clk);
    drive(sel, 1'b0, ~o);
    check({tag, "_busy_acc"}, 32'(get_busy(sel)), 32'd1);
    check({tag, "_vec_acc"}, get_vec(sel), 32'd0);
    cyc = 0;
    while (!get_done(sel) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_table"}, get_tab(sel), exp_tab);
    check({tag, "_busy_done"}, 32'(get_busy(sel)), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(get_done(sel)), 32'd0);
    check({tag, "_table_hold"}, get_tab(sel), exp_tab);
  endtask

  initial begin
    int cyc;
    int dcount;

    // Reset with start held high on every instance
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_vec", 32'(vec_a), 32'd0);
      check("rst_y", 32'(y_a), 32'd0);
      check("rst_tab", 32'(tab_a), 32'd0);
      check("rst_busy", 32'({busy_a, busy_b, busy_c}), 32'd0);
      check("rst_done", 32'({done_a, done_b, done_c}), 32'd0);
    end
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy_a), 32'd0);

    // N=2 HOLD=4 AND: per-cycle vec/y trace
    drive(0, 1'b1, 3'b000);
    @(negedge clk);
    drive(0, 1'b0, 3'b000);
    for (int j = 0; j < 16; j++) begin
      check("and_vec", 32'(vec_a), 32'(j / 4));
      check("and_y", 32'(y_a), 32'((j / 4) == 3));
      check("and_busy", 32'(busy_a), 32'd1);
      check("and_done_early", 32'(done_a), 32'd0);
      @(negedge clk);
    end
    check("and_done", 32'(done_a), 32'd1);
    check("and_busy_end", 32'(busy_a), 32'd0);
    check("and_y_end", 32'(y_a), 32'd0);
    check("and_table", 32'(tab_a), 32'h8);
    @(negedge clk);
    check("and_done_1cyc", 32'(done_a), 32'd0);
    check("and_vec_hold", 32'(vec_a), 32'd3);
    check("and_tab_hold", 32'(tab_a), 32'h8);

    // N=3 HOLD=4
    sweep(1, 3'b010, 32, 32'h96, "n3_xor");
    sweep(1, 3'b101, 32, 32'h69, "n3_xnor");
    sweep(1, 3'b000, 32, 32'h80, "n3_and");

    // N=2 HOLD=1
    sweep(2, 3'b001, 4, 32'hE, "h1_or");
    sweep(2, 3'b011, 4, 32'h7, "h1_nand");
    sweep(2, 3'b100, 4, 32'h1, "h1_nor");
    sweep(2, 3'b110, 4, 32'hA, "h1_buf");
    sweep(2, 3'b111, 4, 32'h5, "h1_not");
    sweep(2, 3'b000, 4, 32'h8, "h1_and");
    sweep(2, 3'b101, 4, 32'h9, "h1_xnor");

    // Mid-sweep op change and start pulse are ignored
    @(negedge clk);
    drive(0, 1'b1, 3'b000);
    @(negedge clk);
    drive(0, 1'b0, 3'b000);
    cyc = 0;
    while (!done_a && cyc < 100) begin
      if (cyc == 4) begin
        check("mid_vec1", 32'(vec_a), 32'd1);
        drive(0, 1'b1, 3'b001);
      end else if (cyc == 5) begin
        drive(0, 1'b0, 3'b001);
      end
      @(negedge clk);
      cyc++;
    end
    check("mid_done_cyc", 32'(cyc), 32'd16);
    check("mid_table", 32'(tab_a), 32'h8);

    // Reset while vec=2: sweep aborted, done never appears
    @(negedge clk);
    drive(0, 1'b1, 3'b000);
    @(negedge clk);
    drive(0, 1'b0, 3'b000);
    repeat (8) @(negedge clk);
    check("rstmid_vec2", 32'(vec_a), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", 32'(busy_a), 32'd0);
    check("rstmid_vec", 32'(vec_a), 32'd0);
    check("rstmid_tab", 32'(tab_a), 32'd0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    check("rstmid_no_done", 32'(dcount), 32'd0);

    // Start accepted on the first edge after reset releases
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 3'b000);
    @(negedge clk);
    drive(0, 1'b0, 3'b000);
    check("post_rst_busy", 32'(busy_a), 32'd1);
    cyc = 0;
    while (!done_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("post_rst_cyc", 32'(cyc), 32'd16);
    check("post_rst_tab", 32'(tab_a), 32'h8);

    // Back-to-back with start held high (N=2 HOLD=1, OR)
    @(negedge clk);
    drive(2, 1'b1, 3'b001);
    cyc = 0;
    while (!done_c && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first_done", 32'(done_c), 32'd1);
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy_c), 32'd0);
    check("b2b_idle_tab", 32'(tab_c), 32'hE);
    @(negedge clk);
    check("b2b_restart_busy", 32'(busy_c), 32'd1);
    check("b2b_restart_tab", 32'(tab_c), 32'd0);
    check("b2b_restart_vec", 32'(vec_c), 32'd0);
    cyc = 2;
    while (!done_c && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_gap", 32'(cyc), 32'd6);
    check("b2b_tab2", 32'(tab_c), 32'hE);
    drive(2, 1'b0, 3'b001);
    repeat (2) @(negedge clk);
    check("b2b_stop_busy", 32'(busy_c), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gate_sweep.md
GATE_SWEEP -- requirements
Module: gate_sweep

Parameters
REQ-001 The block SHALL provide parameter N, default 2, giving the number of gate inputs (legal range 2..6).
REQ-002 The block SHALL provide parameter HOLD, default 4, giving the clock cycles each input vector is held (minimum 1).

Interface
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 op  input  3  gate select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 BUF(vec[0]), 111 NOT(vec[0]).
REQ-007 vec  output  N  input vector currently applied.
REQ-008 y  output  1  selected gate evaluated on vec using the latched op.
REQ-009 table_out  output  2**N  truth table; bit k = gate result for vec = k.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  single-cycle pulse on sweep completion.

Function
REQ-012 FSM states SHALL be IDLE, APPLY and DONE.
- IDLE -> APPLY on start=1.
- APPLY -> DONE after the last vector's final hold cycle.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 On the edge accepting start, op SHALL be latched into op_q, vec cleared to 0, table_out cleared to 0, and the hold counter cleared.
REQ-014 In APPLY, each vector k (0 .. 2**N-1, ascending) SHALL be presented on vec for exactly HOLD consecutive cycles.
REQ-015 On the edge ending vector k's hold, table_out[k] SHALL be written with y; vec then increments, unless vec = 2**N-1, in which case the FSM enters DONE.
REQ-016 Timing: with start accepted at edge E0, vector k SHALL be valid from edge E0+k*HOLD.
- done=1 and busy=0 SHALL hold in the cycle following edge E0+(2**N)*HOLD.
- At that point table_out SHALL be complete.
REQ-017 busy SHALL be 1 exactly while in APPLY; done SHALL be 1 exactly while in DONE.
REQ-018 y SHALL be derived only from registered state (op_q, vec) and SHALL be forced to 0 whenever busy=0.
REQ-019 N-input gates SHALL reduce over all N bits of vec; BUF/NOT SHALL use vec[0] only.
REQ-020 start in APPLY or DONE SHALL be ignored, with no restart and no change to the running sweep.
REQ-021 Changes on op during APPLY SHALL have no effect; only op_q is used.
REQ-022 table_out and vec SHALL retain their final values in DONE and IDLE until the next accepted start or rst.
REQ-023 The vec counter SHALL never wrap during a sweep; the increment after 2**N-1 SHALL be suppressed.

Reset
REQ-024 While rst=1 at an edge, the FSM SHALL go to IDLE; vec, y, table_out, busy, done, op_q and the hold counter SHALL be set to 0.
REQ-025 rst SHALL take priority over start and over any in-progress sweep, including reset mid-APPLY and in DONE.
REQ-026 The cycle after rst deasserts, the block SHALL accept start normally.

Verification
REQ-027 Reset check: assert rst for 2 cycles with start=1 -> all outputs 0, busy stays 0.
REQ-028 N=2, HOLD=4, op=AND, pulse start:
- vec = 0,1,2,3 for 4 cycles each.
- y = 0,0,0,1.
- done pulses 1 cycle at E0+16.
- table_out = 4'b1000.
REQ-029 N=3, HOLD=4, op=XOR -> table_out = 8'b10010110; op=XNOR -> 8'b01101001.
REQ-030 N=2, HOLD=1, op=OR -> done at E0+4, table_out = 4'b1110. Repeat with NAND -> 4'b0111, NOR -> 4'b0001, BUF -> 4'b1010, NOT -> 4'b0101.
REQ-031 Mid-sweep robustness (N=2, HOLD=4, op=AND):
- Toggle op to OR and pulse start while vec=1 -> sweep unaffected, table_out = 4'b1000.
- Assert rst while vec=2 -> next cycle busy=0, vec=0, table_out=0, done never pulses.
REQ-032 Back-to-back: a start held high continuously -> a new sweep begins on the first IDLE cycle after each done pulse, with table_out cleared at acceptance.
